// File: rtl/ysyx_23060096_idu.sv
//------------------------------------------------------------------------------
// ysyx_23060096_idu : RV32 decode stage with a busy-bit scoreboard and a one-entry output buffer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_23060096_idu #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int RW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [RW-1:0]   rf_ra,
    output logic [RW-1:0]   rf_rb,
    input  logic [XLEN-1:0] rf_busA,
    input  logic [XLEN-1:0] rf_busB,
    input  logic            wb_valid,
    input  logic [RW-1:0]   wb_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [RW-1:0]   out_rd,
    output logic            out_rd_wen,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [6:0]      w_opcode;
    logic [RW-1:0]   w_rs1, w_rs2, w_rd;
    logic            w_use_rs1, w_use_rs2, w_wr_rd, w_illegal;
    logic [XLEN-1:0] w_imm;
    logic            w_rd_wen, w_hazard, w_accept;

    logic [NREG-1:0] busy_q, busy_d;
    logic            out_valid_q;
    logic [XLEN-1:0] out_pc_q, out_rs1_q, out_rs2_q, out_imm_q;
    logic [RW-1:0]   out_rd_q;
    logic            out_rd_wen_q, out_f7b5_q, out_illegal_q;
    logic [6:0]      out_opcode_q;
    logic [2:0]      out_funct3_q;

    assign w_opcode = in_inst[6:0];
    assign w_rs1    = in_inst[19:15];
    assign w_rs2    = in_inst[24:20];
    assign w_rd     = in_inst[11:7];
    assign rf_ra    = w_rs1;
    assign rf_rb    = w_rs2;

    // inst[1:0] is part of the 7-bit opcode match, so a non-32-bit encoding lands in default
    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_wr_rd   = 1'b0;
        w_illegal = 1'b0;
        w_imm     = '0;
        case (w_opcode)
            OPC_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_wr_rd   = 1'b1;
            end
            OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
                w_use_rs1 = 1'b1;
                w_wr_rd   = 1'b1;
                w_imm     = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OPC_STORE: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OPC_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm     = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                             in_inst[30:25], in_inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                w_wr_rd = 1'b1;
                w_imm   = {in_inst[31:12], 12'h000};
            end
            OPC_JAL: begin
                w_wr_rd = 1'b1;
                w_imm   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0};
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // The rd term stalls WAW so each register has at most one writer in flight
    assign w_rd_wen = w_wr_rd && (w_rd != '0);
    assign w_hazard = (w_use_rs1 && (w_rs1 != '0) && busy_q[w_rs1]) ||
                      (w_use_rs2 && (w_rs2 != '0) && busy_q[w_rs2]) ||
                      (w_rd_wen && busy_q[w_rd]);
    assign in_ready = !rst && !flush && !w_hazard && (!out_valid_q || out_ready);
    assign w_accept = in_valid && in_ready;

    // Order matters: writeback clear, then accept set (set wins), then flush clear
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (w_accept && w_rd_wen) begin
            busy_d[w_rd] = 1'b1;
        end
        if (flush && out_valid_q && out_rd_wen_q) begin
            busy_d[out_rd_q] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_rs1_q     <= '0;
            out_rs2_q     <= '0;
            out_imm_q     <= '0;
            out_rd_q      <= '0;
            out_rd_wen_q  <= 1'b0;
            out_opcode_q  <= '0;
            out_funct3_q  <= '0;
            out_f7b5_q    <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (w_accept) begin
                out_valid_q   <= 1'b1;
                out_pc_q      <= in_pc;
                out_rs1_q     <= rf_busA;
                out_rs2_q     <= rf_busB;
                out_imm_q     <= w_imm;
                out_rd_q      <= w_rd;
                out_rd_wen_q  <= w_rd_wen;
                out_opcode_q  <= w_opcode;
                out_funct3_q  <= in_inst[14:12];
                out_f7b5_q    <= in_inst[30];
                out_illegal_q <= w_illegal;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_rs1_data = out_rs1_q;
    assign out_rs2_data = out_rs2_q;
    assign out_imm      = out_imm_q;
    assign out_rd       = out_rd_q;
    assign out_rd_wen   = out_rd_wen_q;
    assign out_opcode   = out_opcode_q;
    assign out_funct3   = out_funct3_q;
    assign out_funct7b5 = out_f7b5_q;
    assign out_illegal  = out_illegal_q;

endmodule

`default_nettype wire

// File: doc/ysyx_23060096_idu.md
# ysyx_23060096_idu

Decode stage placed directly upstream of the NPC register file. It accepts fetched instructions over a valid/ready handshake, drives the register file read indices, and generates the immediate. It tracks pending destination registers in a busy-bit scoreboard and stalls on hazards. Decoded operands are registered into a single-entry output buffer that feeds the execute stage.

## Interface
- XLEN, 32, datapath and instruction width
- NREG, 32, architectural register count; index width is clog2(NREG)=5
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  IDU accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  32  instruction PC
- rf_ra / rf_rb  out  5  register file read indices; combinational from in_inst[19:15] and in_inst[24:20]
- rf_busA / rf_busB  in  32  register file combinational read data
- wb_valid  in  1  a writeback to the register file happens this cycle
- wb_rd  in  5  writeback destination index
- flush  in  1  discard the held entry (redirect)
- out_valid  out  1  decoded entry valid
- out_ready  in  1  execute consumes the entry
- out_pc, out_rs1_data, out_rs2_data, out_imm  out  32  registered decode results
- out_rd  out  5;  out_rd_wen  out  1;  out_opcode  out  7;  out_funct3  out  3;  out_funct7b5  out  1;  out_illegal  out  1

## Operation
- Usage sets:
  - rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH and JALR.
  - rs2 is used by OP, STORE and BRANCH.
  - rd is written by OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR.
  - A register index of 0 is never treated as used or written.
- Immediate formats, sign-extended to 32 bits: I, S, B (bit 0 = 0), U (low 12 bits = 0), J (bit 0 = 0). OP produces imm = 0.
- Illegal instructions:
  - An opcode outside the nine listed classes, or inst[1:0] != 2'b11, sets out_illegal = 1 and out_rd_wen = 0.
  - An illegal instruction is still passed downstream.
- Scoreboard: busy[NREG-1:1] holds one bit per register; busy[0] is hardwired to 0.
- hazard = (rs1 used && busy[rs1]) || (rs2 used && busy[rs2]) || (rd written && busy[rd]). The rd term is a WAW stall, which guarantees at most one pending writer per register.
- in_ready = !rst && !flush && !hazard && (!out_valid || out_ready).
- On accept (in_valid && in_ready):
  - The output register loads all decode fields plus rf_busA/rf_busB.
  - If rd is written and rd != 0, busy[rd] is set.
- wb_valid clears busy[wb_rd].
- If the same index is set and cleared in the same cycle, set wins.
- There is no bypass. A register written this cycle reads stale data from the register file, so its busy bit must clear before dependents issue.
- flush:
  - Forces out_valid = 0.
  - If the held entry is valid with out_rd_wen = 1, clears busy[out_rd]. This takes priority over a same-cycle set on that index; no set can occur, because in_ready = 0.
  - Busy bits of entries already passed downstream are untouched; their writebacks still arrive.
- rst clears out_valid, every busy bit and every out_* register to 0, mid-operation included.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented at out_* after edge N.
- Throughput is 1 instruction per cycle when there are no hazards and out_ready = 1.
- out_valid stays high and out_* stay stable while out_ready = 0 (the downstream-stall rule).
- On a simultaneous consume and accept, the new entry replaces the old one at the same edge with no bubble.
- A dependent instruction stalls until the edge at which wb_valid for its source occurs. It is accepted the following cycle at the earliest.
- in_ready is combinational from in_inst, the busy bits, out_valid, out_ready and flush. in_ready never depends on in_valid.

## Test plan
- **Reset:** assert rst for 2 cycles mid-stream with busy[1]=1 -> out_valid=0, all busy bits 0, and in_ready=1 on the first cycle after release.
- **Simple issue:** issue 0x00500093 (addi x1,x0,5) at pc 0x80000000 -> next cycle out_valid=1, out_rd=1, out_rd_wen=1, out_imm=5, busy[1]=1.
- **RAW stall:** issue 0x00108133 (add x2,x1,x1) while busy[1]=1 -> in_ready=0. Pulse wb_valid with wb_rd=1 -> the instruction is accepted on the next cycle, and out_rs1_data equals the value just written to x1.
- **Immediate formats:**
  - 0xfe000ee3 (beq x0,x0,-4) -> out_imm=0xfffffffc, out_rd_wen=0, no busy change.
  - 0x123451b7 (lui x3,0x12345) -> out_imm=0x12345000.
- **Flush and set-wins:**
  - Hold addi x5 with out_ready=0, then assert flush -> out_valid=0 and busy[5]=0.
  - Set busy[6] on accept in the same cycle as wb_valid with wb_rd=6 -> busy[6]=1.
- **Illegal and x0 cases:**
  - 0x00000000 -> out_illegal=1, out_rd_wen=0.
  - addi x0,x0,1 -> no busy bit set, and back-to-back issue with no stall.
